// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulation buffer: seeds the PE array with bias or stored psums per K tile,
// then drains final sums lane-serially. Optional macro PSUM_ERR_EN enables the sticky err flag.
module psum_accum_buffer #(
    parameter int CH     = 8,
    parameter int ACC_W  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       cfg_entries,
    input  logic [7:0]            cfg_k_tiles,
    input  logic                  bias_wr_en,
    input  logic [ADDR_W-1:0]     bias_wr_addr,
    input  logic [CH*ACC_W-1:0]   bias_wr_data,
    output logic                  seed_valid,
    input  logic                  seed_ready,
    output logic [CH*ACC_W-1:0]   seed_data,
    output logic [ADDR_W-1:0]     seed_idx,
    input  logic                  psum_valid,
    input  logic [CH*ACC_W-1:0]   psum_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int ROW_W  = CH * ACC_W;
    localparam int LANE_W = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   e_q, e_d;
    logic [7:0]          t_q, t_d;
    logic [LANE_W-1:0]   l_q, l_d;
    logic [ADDR_W:0]     entries_q, entries_d;
    logic [7:0]          ktiles_q, ktiles_d;

    logic [ROW_W-1:0]    bias_q [DEPTH];
    logic [ROW_W-1:0]    acc_q  [DEPTH];

    logic [ADDR_W:0]     eNext;
    logic [8:0]          tNext;
    logic                lastEntry;
    logic                lastTile;
    logic                lastLane;
    logic [ROW_W-1:0]    accRow;

    assign eNext     = (ADDR_W+1)'(e_q) + (ADDR_W+1)'(1);
    assign tNext     = 9'(t_q) + 9'd1;
    assign lastEntry = (eNext >= entries_q);
    assign lastTile  = (tNext >= {1'b0, ktiles_q});
    assign lastLane  = (l_q == LANE_W'(CH - 1));
    assign accRow    = acc_q[e_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            e_q       <= '0;
            t_q       <= '0;
            l_q       <= '0;
            entries_q <= '0;
            ktiles_q  <= '0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            t_q       <= t_d;
            l_q       <= l_d;
            entries_q <= entries_d;
            ktiles_q  <= ktiles_d;
        end
    end

    // Stores are deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (bias_wr_en) begin
            bias_q[bias_wr_addr] <= bias_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_WAIT && psum_valid) begin
            acc_q[e_q] <= psum_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        t_d       = t_q;
        l_d       = l_q;
        entries_d = entries_q;
        ktiles_d  = ktiles_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    entries_d = cfg_entries;
                    ktiles_d  = (cfg_k_tiles == 8'd0) ? 8'd1 : cfg_k_tiles;
                    e_d       = '0;
                    t_d       = '0;
                    l_d       = '0;
                    state_d   = (cfg_entries != '0) ? S_SEED : S_DONE;
                end
            end
            S_SEED: begin
                if (seed_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (psum_valid) begin
                    if (!lastEntry) begin
                        e_d     = e_q + ADDR_W'(1);
                        state_d = S_SEED;
                    end else begin
                        e_d = '0;
                        t_d = tNext[7:0];
                        l_d = '0;
                        state_d = lastTile ? S_DRAIN : S_SEED;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (lastLane) begin
                        l_d = '0;
                        if (lastEntry) begin
                            state_d = S_DONE;
                        end else begin
                            e_d = e_q + ADDR_W'(1);
                        end
                    end else begin
                        l_d = l_q + LANE_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Tile 0 seeds from bias; later tiles reseed with the stored partial sum.
    assign seed_valid = (state_q == S_SEED);
    assign seed_data  = seed_valid ? ((t_q == 8'd0) ? bias_q[e_q] : accRow) : '0;
    assign seed_idx   = seed_valid ? e_q : '0;

    assign out_valid  = (state_q == S_DRAIN);
    assign out_data   = out_valid ? accRow[l_q*ACC_W +: ACC_W] : '0;
    assign out_last   = out_valid && lastLane && lastEntry;

    assign busy = (state_q == S_SEED) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

`ifdef PSUM_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((psum_valid && state_q != S_WAIT) || (start && busy)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Scoreboard bench for psum_accum_buffer: a small array model answers seeds, expected
// seeds and drain words are queued at job start and popped as the DUT produces them.
module tb_psum_accum_buffer;

    localparam int CH     = 8;
    localparam int ACC_W  = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int ROW_W  = CH * ACC_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [ADDR_W:0]     cfg_entries;
    logic [7:0]          cfg_k_tiles;
    logic                bias_wr_en;
    logic [ADDR_W-1:0]   bias_wr_addr;
    logic [ROW_W-1:0]    bias_wr_data;
    logic                seed_valid;
    logic                seed_ready;
    logic [ROW_W-1:0]    seed_data;
    logic [ADDR_W-1:0]   seed_idx;
    logic                psum_valid;
    logic [ROW_W-1:0]    psum_data;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_W-1:0]    out_data;
    logic                out_last;
    logic                busy;
    logic                done;
    logic                err;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [ROW_W-1:0]  row;
    } seed_t;

    typedef struct {
        logic [ACC_W-1:0] word;
        logic             last;
    } drain_t;

    seed_t            seedQ[$];
    drain_t           outQ[$];
    logic [ROW_W-1:0] mBias [DEPTH];
    logic [ROW_W-1:0] mAcc  [DEPTH];
    int               checks = 0;
    int               passes = 0;

    psum_accum_buffer #(.CH(CH), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_entries(cfg_entries), .cfg_k_tiles(cfg_k_tiles),
        .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data), .seed_idx(seed_idx),
        .psum_valid(psum_valid), .psum_data(psum_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [ROW_W-1:0] got,
                               input logic [ROW_W-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [ROW_W-1:0] addLanes(input logic [ROW_W-1:0] r,
                                                  input logic [ACC_W-1:0] inc);
        logic [ROW_W-1:0] o;
        o = r;
        for (int i = 0; i < CH; i++) o[i*ACC_W +: ACC_W] = r[i*ACC_W +: ACC_W] + inc;
        return o;
    endfunction

    function automatic logic [ROW_W-1:0] laneRow(input int base, input int step);
        logic [ROW_W-1:0] o;
        for (int i = 0; i < CH; i++) o[i*ACC_W +: ACC_W] = ACC_W'(base + step * i);
        return o;
    endfunction

    task automatic writeBias(input int idx, input logic [ROW_W-1:0] row);
        @(negedge clk);
        bias_wr_en   = 1'b1;
        bias_wr_addr = ADDR_W'(idx);
        bias_wr_data = row;
        mBias[idx]   = row;
        @(negedge clk);
        bias_wr_en   = 1'b0;
    endtask

    // Runs one job; abortAfter > 0 resets the DUT while waiting on that seed's result.
    task automatic applyStimulus(input int entries, input int kTiles, input logic [ACC_W-1:0] inc,
                                 input bit stallOut, input int abortAfter);
        int               k;
        seed_t            s;
        drain_t           d;
        bit               pending;
        bit               abortNow;
        bit               finished;
        bit               rdy;
        int               seedsSeen;
        int               drainCyc;
        logic [ROW_W-1:0] psumRow;
        logic [3:0]       pattern;

        pattern = 4'b1001;
        k = (kTiles == 0) ? 1 : kTiles;
        seedQ.delete();
        outQ.delete();
        for (int t = 0; t < k; t++) begin
            for (int e = 0; e < entries; e++) begin
                s.idx = ADDR_W'(e);
                s.row = (t == 0) ? mBias[e] : mAcc[e];
                seedQ.push_back(s);
                mAcc[e] = addLanes(s.row, inc);
            end
        end
        for (int e = 0; e < entries; e++) begin
            for (int l = 0; l < CH; l++) begin
                d.word = mAcc[e][l*ACC_W +: ACC_W];
                d.last = (e == entries - 1) && (l == CH - 1);
                outQ.push_back(d);
            end
        end

        @(negedge clk);
        cfg_entries = (ADDR_W+1)'(entries);
        cfg_k_tiles = 8'(kTiles);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        cfg_entries = 5'd3;
        cfg_k_tiles = 8'd2;

        if (entries == 0) begin
            checkOutput("zeroDone", done, 1);
            checkOutput("zeroSeed", seed_valid, 0);
            @(negedge clk);
            checkOutput("zeroDoneEnd", done, 0);
            checkOutput("zeroBusy", busy, 0);
            checkOutput("zeroSeedEnd", seed_valid, 0);
            return;
        end

        checkOutput("seedLatency", seed_valid, 1);
        checkOutput("busyRun", busy, 1);
        seed_ready = 1'b1;
        pending    = 1'b0;
        abortNow   = 1'b0;
        finished   = 1'b0;
        seedsSeen  = 0;
        drainCyc   = 0;
        psumRow    = '0;

        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            psum_valid = 1'b0;
            checkOutput("noEarlyDone", done, 0);
            if (pending) begin
                pending = 1'b0;
                if (abortNow) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    seed_ready = 1'b0;
                    checkOutput("abortBusy", busy, 0);
                    checkOutput("abortSeed", seed_valid, 0);
                    checkOutput("abortOut", out_valid, 0);
                    checkOutput("abortDone", done, 0);
                    return;
                end
                psum_valid = 1'b1;
                psum_data  = psumRow;
            end
            if (seed_valid) begin
                if (seedQ.size() == 0) begin
                    checkOutput("extraSeed", 1, 0);
                end else begin
                    s = seedQ.pop_front();
                    checkOutput("seedData", seed_data, s.row);
                    checkOutput("seedIdx", seed_idx, s.idx);
                    psumRow = addLanes(s.row, inc);
                    pending = 1'b1;
                    seedsSeen++;
                    if (abortAfter != 0 && seedsSeen == abortAfter) abortNow = 1'b1;
                end
            end
            out_ready = 1'b0;
            if (out_valid) begin
                rdy = stallOut ? pattern[drainCyc % 4] : 1'b1;
                drainCyc++;
                out_ready = rdy;
                if (outQ.size() == 0) begin
                    checkOutput("extraOut", 1, 0);
                end else begin
                    checkOutput("outData", out_data, outQ[0].word);
                    checkOutput("outLast", out_last, outQ[0].last);
                    if (rdy) begin
                        void'(outQ.pop_front());
                        if (outQ.size() == 0) begin
                            @(negedge clk);
                            out_ready = 1'b0;
                            checkOutput("donePulse", done, 1);
                            checkOutput("doneBusy", busy, 0);
                            finished = 1'b1;
                        end
                    end
                end
            end
            if (!finished) @(negedge clk);
        end

        seed_ready = 1'b0;
        if (!finished) checkOutput("timeout", 0, 1);
        checkOutput("seedsConsumed", seedQ.size(), 0);
        @(negedge clk);
        checkOutput("doneOnce", done, 0);
    endtask

    initial begin
        logic errExp;
`ifdef PSUM_ERR_EN
        errExp = 1'b1;
`else
        errExp = 1'b0;
`endif
        rst          = 1'b1;
        start        = 1'b0;
        cfg_entries  = '0;
        cfg_k_tiles  = '0;
        bias_wr_en   = 1'b0;
        bias_wr_addr = '0;
        bias_wr_data = '0;
        seed_ready   = 1'b0;
        psum_valid   = 1'b0;
        psum_data    = '0;
        out_ready    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mBias[i] = '0;
            mAcc[i]  = '0;
        end
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstSeed", seed_valid, 0);
        checkOutput("rstOut", out_valid, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr", err, 0);
        rst = 1'b0;

        $display("[TB] two entries, one tile");
        writeBias(0, laneRow(0, 10));
        writeBias(1, laneRow(100, 10));
        applyStimulus(2, 1, 32'd5, 1'b0, 0);

        $display("[TB] one entry, three tiles");
        writeBias(0, laneRow(1, 0));
        applyStimulus(1, 3, 32'd100, 1'b0, 0);

        $display("[TB] drain backpressure");
        writeBias(0, laneRow(0, 10));
        applyStimulus(2, 1, 32'd5, 1'b1, 0);

        $display("[TB] zero entries");
        applyStimulus(0, 1, 32'd0, 1'b0, 0);

        $display("[TB] reset during wait, then rerun");
        writeBias(0, laneRow(1, 0));
        applyStimulus(1, 3, 32'd100, 1'b0, 2);
        writeBias(0, laneRow(0, 10));
        applyStimulus(2, 1, 32'd5, 1'b0, 0);

        $display("[TB] stray psum in idle");
        checkOutput("errBefore", err, 0);
        @(negedge clk);
        psum_valid = 1'b1;
        @(negedge clk);
        psum_valid = 1'b0;
        checkOutput("errSet", err, errExp);
        checkOutput("strayBusy", busy, 0);
        repeat (3) @(negedge clk);
        checkOutput("errSticky", err, errExp);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("errCleared", err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
